inst_fetch: RTL and testbench

- Instruction fetch stage, directly upstream of the register-file/immediate decoder.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents `inst`, `pc` and `PC_4` to the decoder with a valid flag.
- Supports stall (with a skid/hold register), branch/jump redirect with flush, and a halt on `exit`.

---
 rtl/inst_fetch.sv | 151 +++++++++++++++
 tb/tb_inst_fetch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the register-file/immediate decoder.
//
// Owns the PC and drives a synchronous instruction memory with a 1-cycle read
// latency. It supports stall with a skid/hold register, branch/jump redirect
// with flush (1 bubble), and halt on exit.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   stall        downstream not accepting; hold the presented instruction
//   redirect     taken branch/jal/jalr for the presented instruction
//   redirect_pc  redirect target; bits [1:0] are forced to zero
//   exit         presented instruction is a terminating ecall
//   imem_addr    word address issued to the instruction memory
//   imem_rdata   memory word for the address issued on the previous cycle
//   inst         instruction to the decoder (NOP when not valid)
//   pc, PC_4     address of inst, and that address + 4
//   inst_valid   inst/pc are meaningful
//   halted       fetch stopped by exit; only reset leaves this state
//   perf_fetched consumed-instruction counter (IFETCH_PERF_EN)
//   perf_stalls  stalled-cycle counter (IFETCH_PERF_EN)
//
// Optional feature macro: IFETCH_PERF_EN. When it is undefined, both counters
// read 32'h0 and no counter registers are built.

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               exit,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic [31:0]        PC_4,
  output logic               inst_valid,
  output logic               halted,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] out_pc_q;
  logic        valid_q;
  logic        hold_q;
  logic [31:0] inst_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      out_pc_q    <= RESET_PC;
      valid_q     <= 1'b0;
      hold_q      <= 1'b0;
      inst_hold_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          out_pc_q   <= RESET_PC;
          valid_q    <= 1'b1;
          fetch_pc_q <= RESET_PC + 32'd4;
          hold_q     <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          if (valid_q && exit && !stall) begin
            state_q <= HALT;
            valid_q <= 1'b0;
            hold_q  <= 1'b0;
          end else if (valid_q && redirect) begin
            // The word read this cycle is wrong-path. Dropping valid_q flushes it,
            // and the target is presented after one bubble.
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            valid_q    <= 1'b0;
            hold_q     <= 1'b0;
          end else if (stall) begin
            // fetch_pc is reissued during the stall, so imem_rdata moves on to
            // the next word. The presented word is captured on the first stall edge.
            if (valid_q && !hold_q) begin
              inst_hold_q <= imem_rdata;
              hold_q      <= 1'b1;
            end
          end else begin
            out_pc_q   <= fetch_pc_q;
            valid_q    <= 1'b1;
            fetch_pc_q <= fetch_pc_q + 32'd4;
            hold_q     <= 1'b0;
          end
        end
        HALT: begin
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr  = fetch_pc_q[IMEM_AW+1:2];
  assign inst       = !valid_q ? NOP : (hold_q ? inst_hold_q : imem_rdata);
  assign pc         = out_pc_q;
  assign PC_4       = out_pc_q + 32'd4;
  assign inst_valid = valid_q;
  assign halted     = (state_q == HALT);

  // Address bits that do not reach the memory are collected here on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_pc_q[31:IMEM_AW+2], fetch_pc_q[1:0], redirect_pc[1:0]};

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] stalls_q;

  // valid_q is low in BOOT and HALT, so both counters freeze in those states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else if (valid_q) begin
      if (stall) begin
        stalls_q <= stalls_q + 32'd1;
      end else begin
        fetched_q <= fetched_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch, using RESET_PC=0 and IMEM_AW=14.
// The instruction memory holds 32'hC0DE_0000 + word_index at each word.
module tb_inst_fetch;

  localparam int unsigned AW = 14;
`ifdef IFETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, redirect, exit;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   inst, pc, PC_4, perf_fetched, perf_stalls;
  logic          inst_valid, halted;

  logic [31:0]   mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .exit(exit), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst(inst), .pc(pc), .PC_4(PC_4),
    .inst_valid(inst_valid), .halted(halted),
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input int f, input int s);
    chk({tag, "_fetched"}, perf_fetched, PERF ? 32'(f) : 32'h0);
    chk({tag, "_stalls"},  perf_stalls,  PERF ? 32'(s) : 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; exit = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", PC_4, 32'h4);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk_perf("rst", 0, 0);

    // Release reset. The BOOT cycle issues address 0 and presents nothing valid.
    rst = 1'b1;
    chk("boot_valid", {31'b0, inst_valid}, 32'h0);
    chk("boot_addr", 32'(imem_addr), 32'h0);
    tick();
    chk("a_valid", {31'b0, inst_valid}, 32'h1);
    chk("a_pc", pc, 32'h0);
    chk("a_inst", inst, 32'hC0DE_0000);
    chk("a_pc4", PC_4, 32'h4);
    tick();
    chk("b_pc", pc, 32'h4);
    chk("b_inst", inst, 32'hC0DE_0001);
    chk("b_pc4", PC_4, 32'h8);

    // Stall for 3 edges while B is presented.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", pc, 32'h4);
      chk("stall_inst", inst, 32'hC0DE_0001);
      chk("stall_valid", {31'b0, inst_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    chk("c_pc", pc, 32'h8);
    chk("c_inst", inst, 32'hC0DE_0002);
    chk("c_pc4", PC_4, 32'hC);
    chk_perf("after_stall", 2, 3);

    // Redirect to 0x40 while C is presented.
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("rd_bubble_valid", {31'b0, inst_valid}, 32'h0);
    chk("rd_bubble_inst", inst, NOP);
    chk("rd_addr", 32'(imem_addr), 32'h10);
    tick();
    chk("rd_tgt_valid", {31'b0, inst_valid}, 32'h1);
    chk("rd_tgt_pc", pc, 32'h40);
    chk("rd_tgt_inst", inst, 32'hC0DE_0010);
    chk_perf("after_rd", 3, 3);

    // Redirect to an unaligned target together with stall. The redirect wins.
    redirect = 1'b1; redirect_pc = 32'h0000_0043; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("rd2_bubble_valid", {31'b0, inst_valid}, 32'h0);
    chk("rd2_bubble_inst", inst, NOP);
    tick();
    chk("rd2_tgt_pc", pc, 32'h40);
    chk("rd2_tgt_inst", inst, 32'hC0DE_0010);
    tick();
    chk("adv_pc", pc, 32'h44);
    chk("adv_inst", inst, 32'hC0DE_0011);
    chk_perf("before_exit", 4, 4);

    // Exit while stalled is deferred. A simultaneous redirect loses to exit.
    exit = 1'b1; stall = 1'b1;
    tick();
    chk("exit_stall_halted", {31'b0, halted}, 32'h0);
    chk("exit_stall_valid", {31'b0, inst_valid}, 32'h1);
    chk("exit_stall_inst", inst, 32'hC0DE_0011);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    exit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("halt_halted", {31'b0, halted}, 32'h1);
      chk("halt_valid", {31'b0, inst_valid}, 32'h0);
      chk("halt_inst", inst, NOP);
      chk("halt_pc", pc, 32'h44);
      chk("halt_addr", 32'(imem_addr), 32'h12);
      tick();
    end
    redirect = 1'b0;
    chk_perf("halt", 5, 5);

    // A reset pulse leaves HALT and restarts fetch from RESET_PC.
    rst = 1'b0;
    #2;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_halted", {31'b0, halted}, 32'h0);
    chk("rst2_valid", {31'b0, inst_valid}, 32'h0);
    chk_perf("rst2", 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_a_pc", pc, 32'h0);
    chk("rst2_a_inst", inst, 32'hC0DE_0000);
    chk("rst2_a_valid", {31'b0, inst_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
